seq_detect_param: RTL and testbench

Parametrised serial pattern detector, successor to the fixed 4-bit sequence monitor. It compares a serial bit stream against a runtime-programmable pattern of 1..PAT_W bits, in overlapping or non-overlapping mode. The find pulse is stretched by a programmable, retriggerable hold timer, and a saturating counter tracks matches. It sits on the serial receive path after the bit synchroniser, and its outputs feed status and interrupt logic.

---
 rtl/seq_detect_pkg.sv | 15 +
 rtl/pulse_stretcher.sv | 87 ++++++++
 rtl/seq_detect_param.sv | 111 +++++++++++
 tb/tb_seq_detect_param.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
//   - default parameter constants for seq_detect_param
//   - state encoding for the find-pulse stretcher
package seq_detect_pkg;

  localparam int PAT_W_DEF = 8;   // maximum pattern length in bits
  localparam int STR_W_DEF = 2;   // width of the stretch length
  localparam int CNT_W_DEF = 16;  // width of the match counter

  typedef enum logic {
    IDLE = 1'b0,  // find low, or high for a single cycle when stretch_len is 0
    HOLD = 1'b1   // find held high while the timer runs down
  } stretch_state_e;

endpackage

// File: rtl/pulse_stretcher.sv
// Retriggerable pulse stretcher for the pattern detector's find output.
// A hit raises find on the same edge and keeps it high for stretch_len
// further cycles; a hit while holding reloads the timer.
//
// Ports:
//   clk          clock
//   rst_         asynchronous, active-low reset
//   hit          single-cycle match strobe (already qualified against restart)
//   stretch_len  extra hold cycles after a hit
//   restart      synchronous clear of timer, find and state
//   find         registered, stretched match indication
module pulse_stretcher
  import seq_detect_pkg::*;
#(
  parameter int STR_W = STR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             hit,
  input  logic [STR_W-1:0] stretch_len,
  input  logic             restart,
  output logic             find
);

  stretch_state_e   state, state_next;
  logic [STR_W-1:0] timer, timer_next;
  logic             find_next;

  // NOTE: sequential state is only ever written with non-blocking assignments,
  // so every register samples pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
      timer <= '0;
      find  <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      find  <= find_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next = state;
    timer_next = timer;
    find_next  = find;

    if (restart) begin
      state_next = IDLE;
      timer_next = '0;
      find_next  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          find_next = 1'b0;
          if (hit) begin
            find_next  = 1'b1;
            timer_next = stretch_len;
            if (stretch_len != '0) state_next = HOLD;
          end
        end
        HOLD: begin
          if (hit) begin
            // Retrigger: a fresh hit restarts the full hold period.
            find_next  = 1'b1;
            timer_next = stretch_len;
          end else if (timer == '0) begin
            find_next  = 1'b0;
            state_next = IDLE;
          end else begin
            // Runs on every clock, independent of din_valid, so the hold
            // period is measured in clock cycles, not in data bits.
            timer_next = timer - STR_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          timer_next = '0;
          find_next  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector. Compares the incoming bit stream
// against a programmable pattern of 1..PAT_W bits, in overlapping or
// non-overlapping mode, stretches the find indication and counts matches.
//
// Ports:
//   clk          clock
//   rst_         asynchronous, active-low reset
//   din_valid    din is sampled only when high
//   din          serial data bit
//   pat          pattern; pat[pat_len-1] is the first bit received, pat[0] the last
//   pat_len      active pattern length (0 or > PAT_W disables matching)
//   overlap      1 = overlapping matches; 0 = matched bits are consumed
//   stretch_len  extra cycles find is held after a match
//   restart      synchronous clear of detector state (not the counter)
//   cnt_clr      synchronous clear of match_cnt
//   find         registered match indication (stretched)
//   match_cnt    saturating match count
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int STR_W = STR_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             din_valid,
  input  logic             din,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic [STR_W-1:0] stretch_len,
  input  logic             restart,
  input  logic             cnt_clr,
  output logic             find,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  logic [PAT_W-1:0] sh, sh_next;
  logic [LEN_W-1:0] fill, fill_next;
  logic [PAT_W-1:0] mask;
  logic             len_ok;
  logic             hit;

  // Next-state values of the shift register and fill count; the compare is
  // done on these so find rises on the edge that samples the last bit.
  always_comb begin
    sh_next   = sh;
    fill_next = fill;
    if (din_valid) begin
      sh_next   = {sh[PAT_W-2:0], din};
      fill_next = (fill == PAT_W_L) ? fill : fill + LEN_W'(1);
    end
  end

  // Only the low pat_len bits of the shift register take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < pat_len);
    end
  end

  assign len_ok = (pat_len != '0) && (pat_len <= PAT_W_L);

  // restart wins over a coincident match: no find and no count.
  assign hit = din_valid && !restart && len_ok && (fill_next >= pat_len) &&
               (((sh_next ^ pat) & mask) == '0);

  // NOTE: the shift register is reset along with fill; although fill alone
  // gates matching, a defined reset value keeps the state fully deterministic.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sh   <= '0;
      fill <= '0;
    end else if (restart) begin
      sh   <= '0;
      fill <= '0;
    end else begin
      sh <= sh_next;
      // Non-overlapping mode consumes the matched bits.
      fill <= (hit && !overlap) ? '0 : fill_next;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      // A match on the clearing edge is still counted.
      match_cnt <= hit ? CNT_W'(1) : '0;
    end else if (hit && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

  pulse_stretcher #(
    .STR_W (STR_W)
  ) u_stretch (
    .clk         (clk),
    .rst_        (rst_),
    .hit         (hit),
    .stretch_len (stretch_len),
    .restart     (restart),
    .find        (find)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param. A stimulus process drives one
// input vector per cycle and pushes the reference model's expected outputs
// into a queue; a monitor pops and compares after every active edge.
module tb_seq_detect_param;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int STR_W = 2;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int AGE_INF = 1000;

  logic             clk;
  logic             rst_;
  logic             din_valid;
  logic             din;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic [STR_W-1:0] stretch_len;
  logic             restart;
  logic             cnt_clr;
  logic             find;
  logic [CNT_W-1:0] match_cnt;

  seq_detect_param #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W),
    .STR_W (STR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_        (rst_),
    .din_valid   (din_valid),
    .din         (din),
    .pat         (pat),
    .pat_len     (pat_len),
    .overlap     (overlap),
    .stretch_len (stretch_len),
    .restart     (restart),
    .cnt_clr     (cnt_clr),
    .find        (find),
    .match_cnt   (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             find;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: received bits since the last clear/consume, cycles since
  // the last match, and the match count.
  bit hist[$];
  int age;
  int m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic model_reset();
    hist.delete();
    age   = AGE_INF;
    m_cnt = 0;
  endtask

  // Drive one cycle's inputs, predict the outputs after the next edge.
  task automatic step(input bit dv, input bit d, input bit rs, input bit cc);
    bit   hit;
    int   plen;
    exp_t e;
    din_valid = dv;
    din       = d;
    restart   = rs;
    cnt_clr   = cc;
    hit       = 1'b0;
    plen      = int'(pat_len);
    if (rs) begin
      hist.delete();
      age = AGE_INF;
    end else begin
      if (dv) begin
        hist.push_back(d);
        if (hist.size() > PAT_W) void'(hist.pop_front());
        if (plen >= 1 && plen <= PAT_W && hist.size() >= plen) begin
          hit = 1'b1;
          for (int k = 0; k < plen; k++)
            if (hist[hist.size() - 1 - k] != pat[k]) hit = 1'b0;
        end
        if (hit && !overlap) hist.delete();
      end
      if (hit) age = 0;
      else if (age < AGE_INF) age++;
    end
    if (cc) m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
    e.find = (age <= int'(stretch_len));
    e.cnt  = CNT_W'(m_cnt);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Load a configuration together with restart.
  task automatic cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                     input bit ov, input logic [STR_W-1:0] sl);
    pat         = p;
    pat_len     = l;
    overlap     = ov;
    stretch_len = sl;
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Feed n valid bits, most significant first.
  task automatic feed(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (rst_ && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("find", 32'(find), 32'(e.find));
      check("match_cnt", 32'(match_cnt), 32'(e.cnt));
    end
  end

  initial begin
    rst_        = 1'b0;
    din_valid   = 1'b0;
    din         = 1'b0;
    pat         = '0;
    pat_len     = '0;
    overlap     = 1'b0;
    stretch_len = '0;
    restart     = 1'b0;
    cnt_clr     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_find", 32'(find), 32'd0);
    check("reset_match_cnt", 32'(match_cnt), 32'd0);
    rst_ = 1'b1;
    @(negedge clk);

    // Overlapping 1001: matches after bits 4 and 7.
    cfg(8'b1001, 4'd4, 1'b1, 2'd0);
    feed(32'b1001001, 7);
    idle(2);

    // Non-overlapping: only bit 4 matches, then a fresh 1001 matches again.
    cfg(8'b1001, 4'd4, 1'b0, 2'd0);
    feed(32'b1001001, 7);
    feed(32'b1001, 4);
    step(1'b0, 1'b0, 1'b0, 1'b1);  // cnt_clr alone
    idle(1);

    // Stretch 3 with a retrigger two cycles after the first match.
    cfg(8'b10, 4'd2, 1'b1, 2'd3);
    feed(32'b10, 2);
    idle(6);
    feed(32'b1010, 4);
    idle(7);

    // Gaps in din_valid do not break a partial match.
    cfg(8'b1001, 4'd4, 1'b1, 2'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Out-of-range lengths never match.
    cfg(8'b1001, 4'd0, 1'b1, 2'd0);
    feed(32'b10011001, 8);
    cfg(8'b1001, 4'd9, 1'b1, 2'd0);
    feed(32'hFFFF_FFFF, 12);

    // Saturation at CNT_MAX, then cnt_clr together with a hit.
    cfg(8'b1, 4'd1, 1'b1, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(1);

    // Asynchronous reset in the middle of a hold period.
    cfg(8'b1, 4'd1, 1'b1, 2'd3);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_ = 1'b0;
    #1;
    check("async_rst_find", 32'(find), 32'd0);
    check("async_rst_match_cnt", 32'(match_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_        = 1'b1;
    pat         = 8'b1001;
    pat_len     = 4'd4;
    overlap     = 1'b0;
    stretch_len = 2'd1;
    @(negedge clk);
    feed(32'b001, 3);
    feed(32'b1001, 4);
    idle(3);

    // restart on the edge of a would-be hit.
    cfg(8'b1, 4'd1, 1'b1, 2'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Randomised blocks, each with its own configuration.
    for (int b = 0; b < 10; b++) begin
      cfg(PAT_W'($urandom), LEN_W'($urandom_range(0, 9)), 1'($urandom),
          STR_W'($urandom_range(0, 3)));
      for (int i = 0; i < 200; i++)
        step(($urandom_range(0, 3) != 0), 1'($urandom),
             ($urandom_range(0, 63) == 0), ($urandom_range(0, 49) == 0));
    end
    idle(2);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
